// File: rtl/conv_pkg.sv
// Shared types and width helpers for the streaming KxK convolution engine.
package conv_pkg;

  // Frame-level control: wait for a frame, stream it, then flush the MAC pipeline.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Stage-2 sum width: full-precision product plus log2 of the tap count.
  function automatic int acc_width(input int data_w, input int k);
    return 2 * data_w + $clog2(k * k);
  endfunction

  // Counter width for a count range of n values (never zero).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of delay: DEPTH-entry shift store that advances only on en.
// Contents are not reset; every entry is overwritten before it reaches a window.
module conv_line_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 14
) (
  input  logic              clk,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Shift one position per accepted pixel; hold during stalls.
  always_comb begin
    mem_d = mem_q;
    if (en) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  // Storage register (no reset needed, data only).
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv2d_stream_param.sv
// Streaming KxK 2-D convolution, one pixel per accepted beat, valid (no-pad) output map.
// Line buffers feed a KxK window; stage 1 registers K*K products, stage 2 registers the sum.
// Optional build macro: CONV_RELU_EN clamps negative results to zero when SIGNED=1.
module conv2d_stream_param
  import conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 14,
  parameter int IMG_H  = 14,
  parameter int K      = 3,
  parameter int SIGNED = 0,
  parameter int ACC_W  = acc_width(DATA_W, K)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] In_IFM,
  input  logic [DATA_W-1:0] In_Weight,
  output logic              out_valid,
  output logic [ACC_W-1:0]  Out_OFM,
  output logic              frame_done,
  output logic              busy
);

  localparam int NTAP   = K * K;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ROW_W  = cnt_width(IMG_H);
  localparam int COL_W  = cnt_width(IMG_W);
  localparam int BEAT_W = cnt_width(IMG_H * IMG_W);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(K - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic SGN = (SIGNED != 0);

  state_t state_q, state_d;
  logic   drain_q, drain_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic accept, last_beat;

  logic v0_q, v0_d, last0_q, last0_d;
  logic v1_q, v1_d, last1_q, last1_d;
  logic out_valid_q, out_valid_d, frame_done_q, frame_done_d;
  logic [ACC_W-1:0] out_q, out_d;

  logic [DATA_W-1:0] wgt_q [NTAP];
  logic [DATA_W-1:0] wgt_d [NTAP];
  logic [DATA_W-1:0] win_q [K][K];
  logic [DATA_W-1:0] win_d [K][K];
  logic [PROD_W-1:0] prod_q [NTAP];
  logic [PROD_W-1:0] prod_d [NTAP];
  logic [ACC_W-1:0]  sum_d, res_d;

  logic [DATA_W-1:0] lb_in  [K-1];
  logic [DATA_W-1:0] lb_out [K-1];
  logic [DATA_W-1:0] col_v  [K];

  // Accept rule and end-of-frame detection; beats during DRAIN are dropped.
  always_comb begin
    accept    = in_valid && (state_q != DRAIN);
    last_beat = accept && (row_q == ROW_LAST) && (col_q == COL_LAST);
  end

  // Frame FSM: IDLE -> RUN on first beat, RUN -> DRAIN on last beat, DRAIN lasts two cycles.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        drain_d = 1'b0;
        if (accept) state_d = last_beat ? DRAIN : RUN;
      end
      RUN: begin
        drain_d = 1'b0;
        if (last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = IDLE;
          drain_d = 1'b0;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        drain_d = 1'b0;
      end
    endcase
  end

  // Raster position of the next pixel; wraps to (0,0) after the last pixel of a frame.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    beat_d = beat_q;
    if (accept) begin
      if (last_beat) begin
        row_d  = '0;
        col_d  = '0;
        beat_d = '0;
      end else begin
        beat_d = beat_q + BEAT_W'(1);
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
    end
  end

  // Line-buffer chain: buffer gi delays the pixel stream by gi+1 rows.
  generate
    for (genvar gi = 0; gi < K - 1; gi++) begin : g_lb
      if (gi == 0) begin : g_head
        assign lb_in[gi] = In_IFM;
      end else begin : g_tail
        assign lb_in[gi] = lb_out[gi-1];
      end
      conv_line_buffer #(
        .DATA_W(DATA_W),
        .DEPTH (IMG_W)
      ) u_lb (
        .clk (clk),
        .en  (accept),
        .din (lb_in[gi]),
        .dout(lb_out[gi])
      );
      assign col_v[K-2-gi] = lb_out[gi];
    end
  endgenerate
  assign col_v[K-1] = In_IFM;

  // Window slides one column left per accepted pixel; newest column enters on the right.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int a = 0; a < K; a++) begin
        for (int b = 0; b < K - 1; b++) begin
          win_d[a][b] = win_q[a][b+1];
        end
        win_d[a][K-1] = col_v[a];
      end
    end
  end

  // Kernel capture: frame beat n < K*K loads coefficient n.
  always_comb begin
    wgt_d = wgt_q;
    for (int i = 0; i < NTAP; i++) begin
      if (accept && (beat_q == BEAT_W'(i))) wgt_d[i] = In_Weight;
    end
  end

  // Stage 1: one product per tap, operands widened (sign- or zero-) to full product width.
  generate
    for (genvar gi = 0; gi < NTAP; gi++) begin : g_mul
      logic [PROD_W-1:0] w_ext, p_ext;
      // Widen operands and multiply; low PROD_W bits are exact in both modes.
      always_comb begin
        w_ext = {{DATA_W{SGN & wgt_q[gi][DATA_W-1]}}, wgt_q[gi]};
        p_ext = {{DATA_W{SGN & win_q[gi/K][gi%K][DATA_W-1]}}, win_q[gi/K][gi%K]};
        prod_d[gi] = w_ext * p_ext;
      end
    end
  endgenerate

  // Stage 2: accumulate all products at ACC_W, then optional clamp.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NTAP; i++) begin
      sum_d = sum_d + {{(ACC_W-PROD_W){SGN & prod_q[i][PROD_W-1]}}, prod_q[i]};
    end
`ifdef CONV_RELU_EN
    res_d = (SGN && sum_d[ACC_W-1]) ? '0 : sum_d;
`else
    res_d = sum_d;
`endif
  end

  // Valid/last tags travel alongside the data; Out_OFM only changes with a new result.
  always_comb begin
    v0_d         = accept && (row_q >= ROW_MIN) && (col_q >= COL_MIN);
    last0_d      = last_beat;
    v1_d         = v0_q;
    last1_d      = last0_q;
    out_valid_d  = v1_q;
    frame_done_d = v1_q && last1_q;
    out_d        = v1_q ? res_d : out_q;
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      drain_q      <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      beat_q       <= '0;
      v0_q         <= 1'b0;
      last0_q      <= 1'b0;
      v1_q         <= 1'b0;
      last1_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      row_q        <= row_d;
      col_q        <= col_d;
      beat_q       <= beat_d;
      v0_q         <= v0_d;
      last0_q      <= last0_d;
      v1_q         <= v1_d;
      last1_q      <= last1_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      out_q        <= out_d;
    end
  end

  // Datapath registers; fully overwritten before use, so no reset.
  always_ff @(posedge clk) begin
    wgt_q  <= wgt_d;
    win_q  <= win_d;
    prod_q <= prod_d;
  end

  assign out_valid  = out_valid_q;
  assign Out_OFM    = out_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE) || out_valid_q;

endmodule

// File: tb/tb_conv2d_stream_param.sv
// Self-checking bench for conv2d_stream_param (default geometry, plus a SIGNED=1 instance).
module tb_conv2d_stream_param;

  localparam int DW = 16;
  localparam int IW = 14;
  localparam int IH = 14;
  localparam int KK = 3;
  localparam int AW = 36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, out_valid, frame_done, busy;
  logic [DW-1:0] in_ifm, in_wgt;
  logic [AW-1:0] out_ofm;

  logic          s_in_valid, s_out_valid, s_frame_done, s_busy;
  logic [DW-1:0] s_ifm, s_wgt;
  logic [AW-1:0] s_out;

  conv2d_stream_param #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .K(KK), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .In_IFM(in_ifm), .In_Weight(in_wgt),
    .out_valid(out_valid), .Out_OFM(out_ofm), .frame_done(frame_done), .busy(busy)
  );

  conv2d_stream_param #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .K(KK), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .In_IFM(s_ifm), .In_Weight(s_wgt),
    .out_valid(s_out_valid), .Out_OFM(s_out), .frame_done(s_frame_done), .busy(s_busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int reset_cyc = -1;
  bit chk_en = 1'b0;

  typedef struct {
    int            due;
    logic [AW-1:0] val;
    bit            last;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] got_q[$];
  logic [AW-1:0] s_got[$];
  int            done_cnt = 0;
  int            s_done = 0;
  logic [AW-1:0] last_out = '0;

  longint img[IH][IW];
  longint wk[KK*KK];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: valid-convolution output whose window ends at pixel (r,c).
  function automatic longint win_sum(input int r, input int c);
    longint s = 0;
    for (int a = 0; a < KK; a++)
      for (int b = 0; b < KK; b++)
        s += wk[a*KK+b] * img[r-KK+1+a][c-KK+1+b];
    return s;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Compare process: every cycle, the main DUT either delivers the due result or idles/holds.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      if (out_valid) got_q.push_back(out_ofm);
      if (frame_done) done_cnt++;
      if (cyc == reset_cyc) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_Out_OFM", out_ofm, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        last_out = '0;
      end else begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          chk("out_valid", out_valid, 1);
          chk("Out_OFM", out_ofm, exp_q[0].val);
          chk("frame_done", frame_done, exp_q[0].last);
          void'(exp_q.pop_front());
        end else begin
          chk("idle_out_valid", out_valid, 0);
          chk("idle_frame_done", frame_done, 0);
          chk("hold_Out_OFM", out_ofm, last_out);
        end
        if (out_valid) last_out = out_ofm;
      end
    end
  end

  // Capture for the signed instance.
  initial forever begin
    @(negedge clk);
    if (s_out_valid) s_got.push_back(s_out);
    if (s_frame_done) s_done++;
  end

  // pmode: 0 ramp 14r+c, 1 random. wmode: 0 all ones, 1 identity, 2 random.
  task automatic run_frame(input int pmode, input int wmode, input int gap_pct, input int abort_at);
    exp_t e;
    int r, c;
    for (int i = 0; i < IH; i++)
      for (int j = 0; j < IW; j++)
        img[i][j] = (pmode == 0) ? longint'(14 * i + j) : longint'($urandom_range(65535));
    for (int i = 0; i < KK*KK; i++)
      wk[i] = (wmode == 0) ? 1 : (wmode == 1) ? ((i == (KK*KK)/2) ? 1 : 0) : longint'($urandom_range(65535));
    for (int n = 0; n < IH*IW; n++) begin
      r = n / IW;
      c = n % IW;
      if (n == abort_at) begin
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
        reset_cyc = cyc + 1;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      while ($urandom_range(99) < gap_pct) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_ifm = DW'($urandom);
        in_wgt = DW'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_ifm = DW'(img[r][c]);
      if (n < KK*KK) in_wgt = DW'(wk[n]);
      else in_wgt = DW'($urandom);
      if (r >= KK-1 && c >= KK-1) begin
        e.due = cyc + 3;
        e.val = AW'(win_sum(r, c));
        e.last = (n == IH*IW-1);
        exp_q.push_back(e);
      end
      if (n == (IH*IW)/2) chk("busy_mid_frame", busy, 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic settle_and_check(input string tag, input int nres, input int ndone);
    repeat (3) @(negedge clk);
    chk({tag, "_count"}, got_q.size(), nres);
    chk({tag, "_done_pulses"}, done_cnt, ndone);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic clear_capture();
    got_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d required 0 pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] s_exp;
    rst_n = 1'b0;
    in_valid = 1'b0; in_ifm = '0; in_wgt = '0;
    s_in_valid = 1'b0; s_ifm = '0; s_wgt = '0;
    repeat (3) @(negedge clk);
    chk("por_out_valid", out_valid, 0);
    chk("por_Out_OFM", out_ofm, 0);
    chk("por_frame_done", frame_done, 0);
    chk("por_busy", busy, 0);
    chk("por_s_busy", s_busy, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Ramp image, all-ones kernel, no gaps.
    clear_capture();
    run_frame(0, 0, 0, -1);
    settle_and_check("ones", 144, 1);
    chk("ones_first", got_q[0], 135);
    chk("ones_second", got_q[1], 144);
    chk("model_pin_first", win_sum(2, 2), 135);
    chk("model_pin_second", win_sum(2, 3), 144);

    // Identity kernel with ~30% input gaps.
    clear_capture();
    run_frame(0, 1, 30, -1);
    settle_and_check("ident", 144, 1);
    chk("ident_first", got_q[0], 15);
    chk("ident_row_end", got_q[11], 26);
    chk("ident_row_next", got_q[12], 29);
    chk("ident_last", got_q[143], 180);

    // Random image and kernel with gaps.
    clear_capture();
    run_frame(1, 2, 30, -1);
    settle_and_check("rand", 144, 1);

    // Reset at beat 100, then a fresh frame.
    run_frame(0, 0, 0, 100);
    clear_capture();
    run_frame(0, 0, 0, -1);
    settle_and_check("after_rst", 144, 1);
    chk("after_rst_first", got_q[0], 135);

    // Two frames back to back with different random kernels.
    clear_capture();
    run_frame(1, 2, 0, -1);
    run_frame(1, 2, 0, -1);
    settle_and_check("b2b", 288, 2);

    // Signed instance: IFM=1, weights=-1.
`ifdef CONV_RELU_EN
    s_exp = '0;
`else
    s_exp = 36'hF_FFFF_FFF7;
`endif
    s_got.delete();
    s_done = 0;
    for (int n = 0; n < IH*IW; n++) begin
      @(negedge clk);
      s_in_valid = 1'b1;
      s_ifm = 16'd1;
      s_wgt = 16'hFFFF;
    end
    @(negedge clk);
    s_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("signed_count", s_got.size(), 144);
    chk("signed_done_pulses", s_done, 1);
    chk("signed_busy_after", s_busy, 0);
    for (int i = 0; i < s_got.size(); i++) chk("signed_value", s_got[i], s_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
